// File: rtl/scie_pkg.sv
// Shared constants and types for the scie_pipelined custom-instruction accelerator.
package scie_pkg;

    localparam int SCIE_XLEN  = 32;
    localparam int SCIE_DEPTH = 8;

    localparam logic [6:0] OP_WRITE = 7'h0B;
    localparam logic [6:0] OP_QUERY = 7'h2B;
    localparam logic [6:0] OP_READ  = 7'h5B;
    localparam logic [6:0] OP_CLEAR = 7'h7B;

    typedef logic signed [SCIE_XLEN-1:0] word_t;

endpackage

// File: rtl/scie_match_reduce.sv
// Two-stage threshold query: per-entry signed compare registered as a mask,
// then the mask is reduced to the sum of matching indices into the result register.
module scie_match_reduce #(
    parameter int XLEN  = scie_pkg::SCIE_XLEN,
    parameter int DEPTH = scie_pkg::SCIE_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    query_i,
    input  logic [XLEN-1:0]         key_i,
    input  logic [DEPTH*XLEN-1:0]   table_i,
    input  logic [DEPTH-1:0]        valid_i,
    output logic [XLEN-1:0]         result_o
);

    logic [DEPTH-1:0] mask_d;
    logic [DEPTH-1:0] mask_q;
    logic             pend_q;
    logic [XLEN-1:0]  sum_d;
    logic [XLEN-1:0]  result_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign mask_d[gi] = valid_i[gi] &&
                                ($signed(table_i[gi*XLEN +: XLEN]) <= $signed(key_i));
        end
    endgenerate

    // Stage 1 captures the mask only on a query so later writes cannot disturb it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= query_i;
            if (query_i) begin
                mask_q <= mask_d;
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mask_q[i]) begin
                sum_d = sum_d + XLEN'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else if (pend_q) begin
            result_q <= sum_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/scie_pipelined.sv
// SCIE-style accelerator top: value table, opcode decode and io_rd register.
// Define SCIE_CLEAR_EN to enable the CLEAR opcode (drops all valid bits, keeps data).
module scie_pipelined
    import scie_pkg::*;
#(
    parameter int XLEN  = SCIE_XLEN,
    parameter int DEPTH = SCIE_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    input  logic [31:0]     io_insn,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    output logic [XLEN-1:0] io_rd
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [6:0]            opcode;
    logic                  wr_en;
    logic                  query_en;
    logic                  read_en;
    logic                  clr_en;
    logic [IW-1:0]         wr_idx;
    logic [XLEN-1:0]       table_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [DEPTH*XLEN-1:0] table_flat;
    logic [XLEN-1:0]       result;
    logic [XLEN-1:0]       rd_q;

    assign opcode   = io_insn[6:0];
    assign wr_en    = io_valid && (opcode == OP_WRITE);
    assign query_en = io_valid && (opcode == OP_QUERY);
    assign read_en  = io_valid && (opcode == OP_READ);
    assign wr_idx   = io_rs2[IW-1:0];

`ifdef SCIE_CLEAR_EN
    assign clr_en = io_valid && (opcode == OP_CLEAR);
`else
    assign clr_en = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{io_insn[31:7], io_rs2[XLEN-1:IW]};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    table_q[gi] <= '0;
                end else if (wr_en && (wr_idx == IW'(gi))) begin
                    table_q[gi] <= io_rs1;
                end
            end

            // A write in the same cycle as a clear leaves its own entry valid.
            always_comb begin
                valid_d[gi] = clr_en ? 1'b0 : valid_q[gi];
                if (wr_en && (wr_idx == IW'(gi))) begin
                    valid_d[gi] = 1'b1;
                end
            end

            assign table_flat[gi*XLEN +: XLEN] = table_q[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    scie_match_reduce #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_match_reduce (
        .clock    (clock),
        .reset    (reset),
        .query_i  (query_en),
        .key_i    (io_rs1),
        .table_i  (table_flat),
        .valid_i  (valid_q),
        .result_o (result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else if (read_en) begin
            rd_q <= result;
        end
    end

    assign io_rd = rd_q;

endmodule

// File: tb/tb_scie_pipelined.sv
// Self-checking bench for scie_pipelined: READ results are checked against a
// scoreboard of expected values pushed when each READ is issued.
module tb_scie_pipelined;
    import scie_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_valid = 1'b0;
    logic [31:0] io_insn = '0;
    logic [31:0] io_rs1 = '0;
    logic [31:0] io_rs2 = '0;
    logic [31:0] io_rd;

    int n_cmp = 0;
    int n_bad = 0;
    word_t sb[$];
    word_t exp_v;

    scie_pipelined dut (
        .clock    (clock),
        .reset    (reset),
        .io_valid (io_valid),
        .io_insn  (io_insn),
        .io_rs1   (io_rs1),
        .io_rs2   (io_rs2),
        .io_rd    (io_rd)
    );

    always #5 clock = ~clock;

    // One instruction per cycle; outputs sampled 1 time unit after the edge.
    task automatic issue(input logic [6:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic vld = 1'b1);
        io_valid = vld;
        io_insn  = {25'h1A5A5A5, op};
        io_rs1   = rs1;
        io_rs2   = rs2;
        @(posedge clock);
        #1;
        io_valid = 1'b0;
        io_insn  = '0;
    endtask

    task automatic idle();
        issue(7'h00, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic read_push(input int expected);
        sb.push_back(word_t'(expected));
        issue(OP_READ, 32'd0, 32'd0);
    endtask

    task automatic query_read(input int key, input int expected, input string name);
        issue(OP_QUERY, key, 32'd0);
        idle();
        read_push(expected);
        exp_v = sb.pop_front();
        n_cmp++;
        $display("query %-14s key=%0d io_rd=%0d exp=%0d", name, key, $signed(io_rd), exp_v);
        if (io_rd !== exp_v) begin
            n_bad++;
            $display("FAIL %s: io_rd=%0d required=%0d", name, $signed(io_rd), exp_v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        n_cmp++;
        $display("reset io_rd=%0d", io_rd);
        if (io_rd !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_rd: io_rd=%0d required=0", io_rd);
        end
        read_push(0);
        exp_v = sb.pop_front();
        n_cmp++;
        $display("read no-query io_rd=%0d exp=%0d", io_rd, exp_v);
        if (io_rd !== exp_v) begin
            n_bad++;
            $display("FAIL read_no_query: io_rd=%0d required=%0d", io_rd, exp_v);
        end
        query_read(100, 0, "empty_table");
    endtask

    task automatic test_basic();
        issue(OP_WRITE, 6, 0);
        issue(OP_WRITE, 2, 1);
        issue(OP_WRITE, 8, 2);
        issue(OP_WRITE, 5, 3);
        issue(OP_WRITE, 4, 32'h0100_0004);       // upper index bits ignored
        issue(OP_WRITE, -50, 6, 1'b0);            // io_valid low: no write
        issue(7'h33, -50, 7);                      // unknown opcode: no write
        query_read(2, 1, "key2");
        query_read(4, 5, "key4");
        query_read(0, 0, "key0");
        query_read(8, 10, "key8");
    endtask

    task automatic test_back_to_back();
        issue(OP_QUERY, 2, 0);
        issue(OP_QUERY, 8, 0);
        read_push(1);
        exp_v = sb.pop_front();
        n_cmp++;
        $display("b2b read+1 io_rd=%0d exp=%0d", io_rd, exp_v);
        if (io_rd !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_read_plus1: io_rd=%0d required=%0d", io_rd, exp_v);
        end
        read_push(10);
        exp_v = sb.pop_front();
        n_cmp++;
        $display("b2b read+2 io_rd=%0d exp=%0d", io_rd, exp_v);
        if (io_rd !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_read_plus2: io_rd=%0d required=%0d", io_rd, exp_v);
        end
        repeat (3) idle();
        n_cmp++;
        $display("hold io_rd=%0d exp=10", io_rd);
        if (io_rd !== 32'd10) begin
            n_bad++;
            $display("FAIL rd_hold: io_rd=%0d required=10", io_rd);
        end
    endtask

    task automatic test_overwrite();
        issue(OP_QUERY, 4, 0);
        issue(OP_WRITE, 9, 1);
        read_push(5);
        exp_v = sb.pop_front();
        n_cmp++;
        $display("inflight io_rd=%0d exp=%0d", io_rd, exp_v);
        if (io_rd !== exp_v) begin
            n_bad++;
            $display("FAIL inflight_isolation: io_rd=%0d required=%0d", io_rd, exp_v);
        end
        query_read(4, 4, "after_overwrite");
    endtask

    task automatic test_negative();
        issue(OP_WRITE, -3, 5);
        query_read(-1, 5, "neg_key_m1");
        query_read(-4, 0, "neg_key_m4");
    endtask

    task automatic test_clear();
        issue(OP_CLEAR, 0, 0);
`ifdef SCIE_CLEAR_EN
        query_read(100, 0, "after_clear");
`else
        query_read(100, 15, "clear_ignored");
`endif
    endtask

    task automatic test_reset_mid_query();
        issue(OP_QUERY, 100, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        idle();
        read_push(0);
        exp_v = sb.pop_front();
        n_cmp++;
        $display("reset mid-query io_rd=%0d exp=%0d", io_rd, exp_v);
        if (io_rd !== exp_v) begin
            n_bad++;
            $display("FAIL reset_mid_query: io_rd=%0d required=%0d", io_rd, exp_v);
        end
        query_read(100, 0, "table_after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overwrite();
        test_negative();
        test_clear();
        test_reset_mid_query();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
